// File: rtl/aes_decrypt_iter_ctrl.sv
// Iterative AES-256 decrypt: one inverse round per cycle over 15 cycles, with key-load
// and block valid/ready handshakes. Round key k sits at chain[k*128 +: 128], in decrypt order.
module aes_decrypt_iter_ctrl #(
  parameter bit REG_KEY_CHAIN = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic [255:0] key_i,
  input  logic         key_v_i,
  output logic         key_ready_o,
  input  logic [127:0] data_i,
  input  logic         v_i,
  output logic         ready_o,
  output logic [127:0] data_o,
  output logic         v_o,
  input  logic         yumi_i,
  output logic         busy_o
);
  typedef enum logic [2:0] {IDLE, KEXP, ROUND, FINAL, DONE} fsm_e;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the field inverse, and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Encryption round key r lands in slot 14-r so the chain reads in decrypt order.
  function automatic logic [1919:0] key_expansion(input logic [255:0] k);
    logic [31:0]   w [0:59];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] c;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++)
      c[(14-r)*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return c;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  fsm_e          fsm, fsm_nxt;
  logic [255:0]  key_r;
  logic [127:0]  st_r;
  logic [3:0]    rnd_r;
  logic          key_loaded_r;
  logic [1919:0] chain;
  logic [15:0][127:0] rks;
  logic [3:0]    rk_idx;
  logic [127:0]  rk, ark, mix;

  generate
    if (REG_KEY_CHAIN) begin : g_chain_reg
      logic [1919:0] chain_r;
      always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i)        chain_r <= '0;
        else if (fsm == KEXP)  chain_r <= key_expansion(key_r);
      assign chain = chain_r;
    end else begin : g_chain_comb
      assign chain = key_expansion(key_r);
    end
  endgenerate

  // ROUND and FINAL share shift/sub/add; only ROUND takes the inverse mix columns.
  assign rks    = {128'h0, chain};
  assign rk_idx = (fsm == FINAL) ? 4'd14 : rnd_r;
  assign rk     = rks[rk_idx];
  assign ark    = inv_sub_bytes(inv_shift_rows(st_r)) ^ rk;

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = ark[127-32*c -: 32];
    assign mix[127-32*c -: 32] = {
      gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
      gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
      gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
      gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) fsm <= IDLE;
    else            fsm <= fsm_nxt;

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (key_v_i)                   fsm_nxt = REG_KEY_CHAIN ? KEXP : IDLE;
               else if (v_i && key_loaded_r)  fsm_nxt = ROUND;
      KEXP:    fsm_nxt = IDLE;
      ROUND:   if (rnd_r == 4'd13) fsm_nxt = FINAL;
      FINAL:   fsm_nxt = DONE;
      DONE:    if (yumi_i) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    key_ready_o = 1'b0;
    ready_o     = 1'b0;
    v_o         = 1'b0;
    busy_o      = 1'b1;
    case (fsm)
      IDLE: begin
        key_ready_o = 1'b1;
        ready_o     = key_loaded_r & ~key_v_i;
        busy_o      = 1'b0;
      end
      DONE:    v_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      key_r        <= '0;
      st_r         <= '0;
      rnd_r        <= '0;
      key_loaded_r <= 1'b0;
    end else begin
      case (fsm)
        IDLE:
          if (key_v_i) begin
            key_r        <= key_i;
            key_loaded_r <= 1'b1;
          end else if (v_i && key_loaded_r) begin
            st_r  <= data_i ^ rks[0];
            rnd_r <= 4'd1;
          end
        ROUND: begin
          st_r <= mix;
          if (rnd_r != 4'd13) rnd_r <= rnd_r + 4'd1;
        end
        FINAL:   st_r <= ark;
        default: ;
      endcase
    end

  assign data_o = st_r;
endmodule

// File: tb/tb_aes_decrypt_iter_ctrl.sv
// Directed bench for aes_decrypt_iter_ctrl; both chain variants share one stimulus.
module tb_aes_decrypt_iter_ctrl;
  localparam logic [255:0] K1  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT1 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K2  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] CT2 = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [127:0] PT2 = 128'h6bc1bee22e409f96e93d7e117393172a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n_i, key_v_i, v_i, yumi_i;
  logic [255:0] key_i;
  logic [127:0] data_i;
  logic         key_ready0, ready0, v0, busy0;
  logic         key_ready1, ready1, v1, busy1;
  logic [127:0] data0, data1;
  int errs = 0, checks = 0;

  aes_decrypt_iter_ctrl #(.REG_KEY_CHAIN(1'b1)) u_dut0 (
    .clk_i(clk), .reset_n_i(reset_n_i), .key_i(key_i), .key_v_i(key_v_i),
    .key_ready_o(key_ready0), .data_i(data_i), .v_i(v_i), .ready_o(ready0),
    .data_o(data0), .v_o(v0), .yumi_i(yumi_i), .busy_o(busy0));

  aes_decrypt_iter_ctrl #(.REG_KEY_CHAIN(1'b0)) u_dut1 (
    .clk_i(clk), .reset_n_i(reset_n_i), .key_i(key_i), .key_v_i(key_v_i),
    .key_ready_o(key_ready1), .data_i(data_i), .v_i(v_i), .ready_o(ready1),
    .data_o(data1), .v_o(v1), .yumi_i(yumi_i), .busy_o(busy1));

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // dut0 passes through KEXP, dut1 does not; one spare cycle resyncs them.
  task automatic load_key(input logic [255:0] k);
    key_i   = k;
    key_v_i = 1'b1;
    #1;
    chk("key_rdy", key_ready0, 1);
    step();
    key_v_i = 1'b0;
    chk("kexp_krdy", key_ready0, 0);
    chk("kexp_rdy", ready0, 0);
    step();
  endtask

  // Accept cycle is cycle 0; v_o is expected in cycle 15 (13 ROUND + FINAL after it).
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt,
                           input int hold, input string tag);
    int n, nb;
    data_i = ct;
    v_i    = 1'b1;
    yumi_i = (hold == 0);
    n = 0;
    while (!ready0 && n < 20) begin step(); n++; end
    chk({tag, "_acc"}, ready0, 1);
    step();
    v_i = 1'b0;
    n  = 1;
    nb = 0;
    while (!v0 && n < 40) begin
      if (busy0) nb++;
      step();
      n++;
    end
    nb++;
    chk({tag, "_lat"}, n, 15);
    chk({tag, "_pt0"}, data0, pt);
    chk({tag, "_pt1"}, data1, pt);
    chk({tag, "_v1"}, v1, 1);
    if (hold == 0) chk({tag, "_busy_cyc"}, nb, 15);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_v"}, v0, 1);
      chk({tag, "_hold_d"}, data0, pt);
      chk({tag, "_hold_rdy"}, ready0, 0);
    end
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    chk({tag, "_post_v"}, v0, 0);
    chk({tag, "_post_busy"}, busy0, 0);
    chk({tag, "_post_rdy"}, ready0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_t [3];
    int na, n0, n1;
    bit drop;
    reset_n_i = 1'b0;
    key_v_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
    key_i = '0; data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v", v0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_krdy", key_ready0, 1);
    chk("rst_rdy", ready0, 0);
    chk("rst_data", data0, 0);
    reset_n_i = 1'b1;
    step();

    // No key loaded: block must not be taken.
    data_i = CT1;
    v_i    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("nokey_rdy", ready0, 0);
      chk("nokey_busy", busy0, 0);
      chk("nokey_v", v0, 0);
      step();
    end
    v_i = 1'b0;

    load_key(K1);
    run_block(CT1, PT1, 0, "fips");
    run_block(CT1, PT1, 20, "bp");

    // Back-to-back with v_i and yumi_i held high.
    data_i = CT1; v_i = 1'b1; yumi_i = 1'b1;
    na = 0; n0 = 0; n1 = 0; drop = 1'b0;
    for (int cyc = 0; cyc < 80 && n0 < 3; cyc++) begin
      if (v_i && ready0) begin
        if (na < 3) acc_t[na] = cyc;
        na++;
        if (na == 3) drop = 1'b1;
      end
      if (v0) begin chk("b2b_pt0", data0, PT1); n0++; end
      if (v1) begin chk("b2b_pt1", data1, PT1); n1++; end
      step();
      if (drop) v_i = 1'b0;
    end
    yumi_i = 1'b0;
    chk("b2b_accepts", na, 3);
    chk("b2b_outs0", n0, 3);
    chk("b2b_outs1", n1, 3);
    chk("b2b_gap01", acc_t[1] - acc_t[0], 16);
    chk("b2b_gap12", acc_t[2] - acc_t[1], 16);
    step();

    // Key load wins over a simultaneous block.
    key_i = K2; key_v_i = 1'b1;
    data_i = CT2; v_i = 1'b1;
    #1;
    chk("sim_rdy0", ready0, 0);
    chk("sim_rdy1", ready1, 0);
    chk("sim_krdy", key_ready0, 1);
    step();
    key_v_i = 1'b0; v_i = 1'b0;
    chk("sim_kexp_busy", busy0, 1);
    chk("sim_kexp_rdy", ready0, 0);
    step();
    run_block(CT2, PT2, 0, "newkey");

    // Asynchronous reset at round 7.
    data_i = CT2; v_i = 1'b1;
    step();
    v_i = 1'b0;
    repeat (6) step();
    chk("mid_busy_pre", busy0, 1);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("mid_v", v0, 0);
    chk("mid_busy", busy0, 0);
    chk("mid_rdy", ready0, 0);
    chk("mid_krdy", key_ready0, 1);
    chk("mid_data", data0, 0);
    step();
    reset_n_i = 1'b1;
    v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("mid_nokey_rdy", ready0, 0);
      step();
      chk("mid_nokey_busy", busy0, 0);
    end
    v_i = 1'b0;
    load_key(K1);
    run_block(CT1, PT1, 0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
